// File: rtl/spike_enc_if.sv
// Intensity handshake and spike output bundle for spike_rate_encoder_3ch.
//   master : producer of intensity triples / consumer of spikes (drives in_valid, i0..i2)
//   slave  : the encoder (drives in_ready, x0..x2, busy, window_done)
interface spike_enc_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] i0;
  logic [7:0] i1;
  logic [7:0] i2;
  logic       x0;
  logic       x1;
  logic       x2;
  logic       busy;
  logic       window_done;

  modport master (
    output in_valid, i0, i1, i2,
    input  in_ready, x0, x1, x2, busy, window_done
  );

  modport slave (
    input  in_valid, i0, i1, i2,
    output in_ready, x0, x1, x2, busy, window_done
  );
endinterface

// File: rtl/spike_rate_encoder_3ch.sv
// Three-channel deterministic rate encoder. Each accepted intensity triple is
// encoded for WINDOW cycles; every cycle each channel adds its intensity to an
// 8-bit phase accumulator and the carry out is that cycle's spike, giving exactly
// floor(WINDOW*I/256) spikes per window.
// Ports:
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : spike_enc_if.slave (in_valid/in_ready handshake, i0..i2 intensities,
//             x0..x2 registered spikes, busy, window_done pulse)
// Optional feature: define SPIKE_ENC_REFRACT_EN for a one-cycle refractory period
// per channel (a carry directly after a spike is discarded, not deferred).
module spike_rate_encoder_3ch #(
  parameter int unsigned WINDOW = 100
) (
  input  logic        clk,
  input  logic        reset_n,
  spike_enc_if.slave  bus
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned NCH   = 3;
  localparam int unsigned IW    = 8;

  typedef enum logic {IDLE, ENCODE} state_e;

  state_e                      state_q, state_d;
  logic [NCH-1:0][IW-1:0]      acc_q, acc_d;
  logic [NCH-1:0][IW-1:0]      int_q, int_d;
  logic [NCH-1:0][IW:0]        sum_c;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [NCH-1:0]              x_q, x_d;
  logic                        busy_q, busy_d;
  logic                        rdy_q, rdy_d;
  logic                        done_q, done_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      int_q   <= '0;
      cnt_q   <= '0;
      x_q     <= '0;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      int_q   <= int_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
      done_q  <= done_d;
    end
  end

  // Next-state, accumulate step and registered-output next values
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    int_d   = int_q;
    cnt_d   = cnt_q;
    x_d     = '0;
    busy_d  = busy_q;
    rdy_d   = rdy_q;
    done_d  = 1'b0;
    sum_c   = '0;

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        rdy_d  = 1'b1;
        if (bus.in_valid && rdy_q) begin
          int_d   = {bus.i2, bus.i1, bus.i0};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ENCODE;
          busy_d  = 1'b1;
          rdy_d   = 1'b0;
        end
      end

      ENCODE: begin
        for (int k = 0; k < NCH; k++) begin
          sum_c[k] = {1'b0, acc_q[k]} + {1'b0, int_q[k]};
          acc_d[k] = sum_c[k][IW-1:0];
`ifdef SPIKE_ENC_REFRACT_EN
          // A carry right after a spike is dropped; the phase still wraps.
          x_d[k]   = sum_c[k][IW] & ~x_q[k];
`else
          x_d[k]   = sum_c[k][IW];
`endif
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_d == CNT_W'(WINDOW)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          rdy_d   = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.in_ready    = rdy_q;
  assign bus.busy        = busy_q;
  assign bus.window_done = done_q;
  assign bus.x0          = x_q[0];
  assign bus.x1          = x_q[1];
  assign bus.x2          = x_q[2];

endmodule

// File: tb/tb_spike_rate_encoder_3ch.sv
// Directed bench for spike_rate_encoder_3ch. Five encoder instances share clk and
// reset_n, each with its own window length: 0:W=100 1:W=10 2:W=4 3:W=1 4:W=256.
module tb_spike_rate_encoder_3ch;

`ifdef SPIKE_ENC_REFRACT_EN
  localparam bit REFR = 1'b1;
`else
  localparam bit REFR = 1'b0;
`endif

  logic clk;
  logic reset_n;

  logic       valid [5];
  logic [7:0] a0    [5];
  logic [7:0] a1    [5];
  logic [7:0] a2    [5];
  logic [2:0] xo    [5];
  logic       busy  [5];
  logic       ready [5];
  logic       done  [5];

  int vecs;
  int errs;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    localparam int unsigned W = (g == 0) ? 100 : (g == 1) ? 10 : (g == 2) ? 4 : (g == 3) ? 1 : 256;
    spike_enc_if ifc ();
    spike_rate_encoder_3ch #(.WINDOW(W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (ifc)
    );
    assign ifc.in_valid = valid[g];
    assign ifc.i0       = a0[g];
    assign ifc.i1       = a1[g];
    assign ifc.i2       = a2[g];
    assign xo[g]        = {ifc.x2, ifc.x1, ifc.x0};
    assign busy[g]      = ifc.busy;
    assign ready[g]     = ifc.in_ready;
    assign done[g]      = ifc.window_done;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offer one triple to instance d and count spikes until window_done (inclusive).
  task automatic run_window(input int d, input logic [7:0] v0, input logic [7:0] v1,
                            input logic [7:0] v2, input int budget,
                            output int n0, output int n1, output int n2, output int steps,
                            output logic [31:0] mask0, output int last0, output bit to);
    n0 = 0; n1 = 0; n2 = 0; steps = 0; mask0 = '0; last0 = 0; to = 1'b1;
    @(negedge clk);
    a0[d] = v0; a1[d] = v1; a2[d] = v2; valid[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid[d] = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk);
      @(negedge clk);
      steps++;
      if (xo[d][0]) begin
        n0++; last0 = steps;
        if (steps <= 32) mask0[steps-1] = 1'b1;
      end
      if (xo[d][1]) n1++;
      if (xo[d][2]) n2++;
      if (done[d]) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int g = 0; g < 5; g++) begin
      valid[g] = 1'b0; a0[g] = '0; a1[g] = '0; a2[g] = '0;
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 5; g++) begin
      vecs++;
      if ({xo[g], busy[g], done[g], ready[g]} !== 6'b000001) begin
        errs++;
        $display("FAIL reset_state dut%0d: got x=%b busy=%b done=%b rdy=%b, expected x=000 busy=0 done=0 rdy=1",
                 g, xo[g], busy[g], done[g], ready[g]);
      end
    end
  endtask

  task automatic test_window100();
    int n0, n1, n2, st, l0; logic [31:0] m0; bit to;
    run_window(0, 8'd128, 8'd0, 8'd255, 200, n0, n1, n2, st, m0, l0, to);
    vecs++; if (to !== 1'b0) begin errs++; $display("FAIL w100_timeout: got timeout=%0d expected 0", to); end
    vecs++; if (st !== 100) begin errs++; $display("FAIL w100_steps: got %0d expected 100", st); end
    vecs++; if (n0 !== 50) begin errs++; $display("FAIL w100_x0_count: got %0d expected 50", n0); end
    vecs++; if (n1 !== 0) begin errs++; $display("FAIL w100_x1_count: got %0d expected 0", n1); end
    vecs++; if (n2 !== (REFR ? 50 : 99)) begin errs++; $display("FAIL w100_x2_count: got %0d expected %0d", n2, REFR ? 50 : 99); end
    vecs++; if (m0 !== 32'hAAAA_AAAA) begin errs++; $display("FAIL w100_x0_pattern: got %h expected aaaaaaaa", m0); end
    vecs++; if ({busy[0], ready[0]} !== 2'b01) begin errs++; $display("FAIL w100_done_flags: got busy=%b rdy=%b expected busy=0 rdy=1", busy[0], ready[0]); end
    @(negedge clk);
    vecs++; if ({xo[0], done[0]} !== 4'b0000) begin errs++; $display("FAIL w100_after_done: got x=%b done=%b expected x=000 done=0", xo[0], done[0]); end
  endtask

  task automatic test_refract();
    int n0, n1, n2, st, l0; logic [31:0] m0; bit to;
    run_window(1, 8'd255, 8'd0, 8'd0, 50, n0, n1, n2, st, m0, l0, to);
    vecs++; if (to !== 1'b0) begin errs++; $display("FAIL w10_timeout: got timeout=%0d expected 0", to); end
    vecs++; if (n0 !== (REFR ? 5 : 9)) begin errs++; $display("FAIL w10_x0_count: got %0d expected %0d", n0, REFR ? 5 : 9); end
    vecs++;
    if (m0[9:0] !== (REFR ? 10'b10_1010_1010 : 10'b11_1111_1110)) begin
      errs++; $display("FAIL w10_x0_steps: got %b expected %b", m0[9:0], REFR ? 10'b10_1010_1010 : 10'b11_1111_1110);
    end
  endtask

  task automatic test_back_to_back();
    int wins, cyc, prev, n0, n1, n2;
    bit to;
    wins = 0; prev = -1; n0 = 0; n1 = 0; n2 = 0; to = 1'b1;
    @(negedge clk);
    a0[2] = 8'd128; a1[2] = 8'd0; a2[2] = 8'd64; valid[2] = 1'b1;
    for (cyc = 0; cyc < 60; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (xo[2][0]) n0++;
      if (xo[2][1]) n1++;
      if (xo[2][2]) n2++;
      if (done[2]) begin
        wins++;
        vecs++; if ({n2, n1, n0} !== {32'd1, 32'd0, 32'd2}) begin
          errs++; $display("FAIL b2b_counts win%0d: got x0=%0d x1=%0d x2=%0d expected 2 0 1", wins, n0, n1, n2);
        end
        if (prev >= 0) begin
          vecs++; if (cyc - prev !== 5) begin errs++; $display("FAIL b2b_period win%0d: got %0d expected 5", wins, cyc - prev); end
        end
        prev = cyc; n0 = 0; n1 = 0; n2 = 0;
        if (wins == 3) begin
          valid[2] = 1'b0; to = 1'b0;
          break;
        end
      end
      // Present the real triple only when it can be latched; noise otherwise.
      if (ready[2]) begin a0[2] = 8'd128; a1[2] = 8'd0; a2[2] = 8'd64; end
      else begin a0[2] = 8'd255; a1[2] = 8'd255; a2[2] = 8'd255; end
    end
    vecs++; if (to !== 1'b0) begin errs++; $display("FAIL b2b_timeout: got %0d windows expected 3", wins); end
    @(negedge clk);
    vecs++; if ({done[2], ready[2]} !== 2'b01) begin errs++; $display("FAIL b2b_idle: got done=%b rdy=%b expected done=0 rdy=1", done[2], ready[2]); end
  endtask

  task automatic test_reset_mid();
    int pulses, lows;
    pulses = 0; lows = 0;
    @(negedge clk);
    a0[0] = 8'd255; a1[0] = 8'd128; a2[0] = 8'd255; valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    vecs++; if (busy[0] !== 1'b1) begin errs++; $display("FAIL midrst_busy_before: got %b expected 1", busy[0]); end
    reset_n = 1'b0;
    #1;
    vecs++; if ({xo[0], busy[0], done[0]} !== 5'b0) begin
      errs++; $display("FAIL midrst_clear: got x=%b busy=%b done=%b expected all 0", xo[0], busy[0], done[0]);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (done[0]) pulses++;
      if (!ready[0]) lows++;
    end
    vecs++; if (pulses !== 0) begin errs++; $display("FAIL midrst_no_done: got %0d pulses expected 0", pulses); end
    vecs++; if (lows !== 0) begin errs++; $display("FAIL midrst_ready: got %0d not-ready cycles expected 0", lows); end
  endtask

  task automatic test_window1();
    int n0, n1, n2, st, l0; logic [31:0] m0; bit to;
    run_window(3, 8'd255, 8'd255, 8'd255, 10, n0, n1, n2, st, m0, l0, to);
    vecs++; if (to !== 1'b0) begin errs++; $display("FAIL w1_timeout: got timeout=%0d expected 0", to); end
    vecs++; if (st !== 1) begin errs++; $display("FAIL w1_steps: got %0d expected 1", st); end
    vecs++; if (n0 + n1 + n2 !== 0) begin errs++; $display("FAIL w1_spikes: got %0d expected 0", n0 + n1 + n2); end
    @(negedge clk);
    vecs++; if (done[3] !== 1'b0) begin errs++; $display("FAIL w1_pulse_width: got done=%b expected 0", done[3]); end
  endtask

  task automatic test_window256();
    int n0, n1, n2, st, l0; logic [31:0] m0; bit to;
    run_window(4, 8'd1, 8'd0, 8'd128, 400, n0, n1, n2, st, m0, l0, to);
    vecs++; if (to !== 1'b0) begin errs++; $display("FAIL w256_timeout: got timeout=%0d expected 0", to); end
    vecs++; if (st !== 256) begin errs++; $display("FAIL w256_steps: got %0d expected 256", st); end
    vecs++; if (n0 !== 1) begin errs++; $display("FAIL w256_x0_count: got %0d expected 1", n0); end
    vecs++; if (l0 !== 256) begin errs++; $display("FAIL w256_x0_step: got %0d expected 256", l0); end
    vecs++; if (n2 !== 128) begin errs++; $display("FAIL w256_x2_count: got %0d expected 128", n2); end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    test_reset();
    test_window100();
    test_refract();
    test_back_to_back();
    test_reset_mid();
    test_window1();
    test_window256();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/spike_rate_encoder_3ch.md
# spike_rate_encoder_3ch

Converts three 8-bit input intensities into three deterministic rate-coded spike trains over a fixed encoding window. It drives the `x0`/`x1`/`x2` spike inputs of the 3-input LIF/Hebbian neuron. It is the front-end producer of spikes that the neuron consumes. Each channel uses a phase accumulator, so the spike count per window is exact and reproducible for learning experiments.

## Interface
- `WINDOW`, default 100: encoding window length in clock cycles. Legal range 1..65535.
- `clk`  in  1  clock; all logic on rising edge.
- `reset_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `in_valid`  in  1  intensity triple offered.
- `in_ready`  out  1  encoder can accept a triple.
- `i0`, `i1`, `i2`  in  8 each  channel intensities (unsigned; spike probability I/256 per cycle).
- `x0`, `x1`, `x2`  out  1 each  registered spike outputs, to the neuron inputs.
- `busy`  out  1  high while encoding a window.
- `window_done`  out  1  one-cycle pulse after the last window cycle.

## Operation
- States: IDLE, ENCODE.
- **Reset** (asserted `reset_n`=0): state IDLE, accumulators 0, cycle counter 0, intensity registers 0. Outputs: `x0`/`x1`/`x2`=0, `busy`=0, `window_done`=0, `in_ready`=1 once `reset_n` is released. Asserting reset mid-window aborts the window immediately; no `window_done` is produced.
- **IDLE**:
  - `in_ready`=1; `x*` registered to 0 each edge.
  - When `in_valid` & `in_ready` are high at an edge: latch `i0..i2`, clear the accumulators and the 16-bit counter, go to ENCODE.
  - Input values are ignored when no handshake occurs.
- **ENCODE**:
  - `in_ready`=0, `busy`=1.
  - Per channel each edge: 9-bit sum = acc + I. `x_k` <= sum[8]. acc <= sum[7:0]. The wrap is modulo 256; the carry is the spike.
  - The counter increments each edge. On the edge where the counter reaches `WINDOW`, go to IDLE and pulse `window_done`.
- Spikes per channel per window = floor(`WINDOW`·I/256) exactly.
- I=0 produces no spikes. I=255 produces a spike on every cycle except those where the carry does not occur.
- Channels are fully independent; simultaneous spikes on all three channels are legal and expected.
- Latched intensities are held for the whole window. Changes on `i*` during ENCODE have no effect.

## Timing
- Edge E0: handshake accepted. Edges E1..E`WINDOW`: accumulate steps.
- `x_k` during the cycle after Ej carries the spike for step j.
- After E`WINDOW`:
  - `busy`=0, `in_ready`=1, `window_done`=1 for exactly one cycle.
  - `x_k` still shows step `WINDOW`.
- Edge E`WINDOW`+1 (IDLE): `x*` cleared and `window_done` cleared. A new handshake may be accepted on this same edge.
- The minimum gap is therefore zero idle-spike cycles lost and one handshake cycle. Back-to-back windows repeat every `WINDOW`+1 edges.
- `WINDOW`=1: one accumulate step, then `window_done`.

## Configuration
- `SPIKE_ENC_REFRACT_EN` defined: one-cycle refractory period per channel.
  - If `x_k` is 1, the next step's carry is discarded: `x_k` <= 0 and acc <= sum[7:0].
  - The discarded spike is lost, not deferred.
- Not defined: no refractory behaviour. Every carry produces a spike, including consecutive cycles.

## Test plan
- Reset with `reset_n`=0, then release → all `x*`=0, `busy`=0, `window_done`=0, `in_ready`=1.
- `WINDOW`=100, i0=128, i1=0, i2=255; count spikes until `window_done` → x0=50, x1=0, x2=99. x0 first fires on step 2 and then alternates.
- `WINDOW`=10, i0=255, macro defined → x0 spikes on steps 2,4,6,8,10 (5 spikes). Without the macro → 9 spikes, steps 2..10.
- Hold `in_valid` high continuously with `WINDOW`=4 → a handshake every 5 edges. `window_done` pulses once per window. `i*` changes during ENCODE do not alter counts.
- Assert `reset_n` low at step 3 of a 100-cycle window → outputs clear immediately, no `window_done`, `in_ready`=1 after release.
- `WINDOW`=1, i0=255 → no spike, `window_done` pulse on the cycle after E1. `WINDOW`=256, i0=1 → exactly 1 spike, on step 256.
